gray_window_3x3: RTL and testbench
==================================

Name: gray_window_3x3

Overview:
- Downstream neighbour of color_control_dualport.
- Consumes the 8-bit grayscale raster stream (one pixel per accepted beat, row-major) and produces a 3x3 neighbourhood window for every pixel position.
- Feeds the planned spatial filter stages (Sobel/blur).
- Holds two line buffers plus a 3x3 register window, pads image borders, and flushes the final row without further input.

Parameters:
- IMG_WIDTH, 220, pixels per row (>=2)
- IMG_HEIGHT, 220, rows per frame (>=2)
- DATA_WIDTH, 8, bits per gray pixel

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; arms a new frame (honoured only in IDLE)
- in_valid  in  1  in_data valid this cycle
- in_data  in  DATA_WIDTH  gray pixel
- in_ready  out  1  block accepts in_data; a beat is accepted when in_valid && in_ready
- win_valid  out  1  win_data/out_row/out_col valid this cycle (no downstream stall)
- win_data  out  9*DATA_WIDTH  window; element k=3*i+j at bits [DATA_WIDTH*k +: DATA_WIDTH], i=row (0=top), j=col (0=left), centre is k=4
- out_row  out  clog2(IMG_HEIGHT)  centre row of current window
- out_col  out  clog2(IMG_WIDTH)  centre column of current window
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last window emitted

Behaviour:
- Reset: all outputs 0; state IDLE; row/col counters 0.
  - Line-buffer RAM contents are not cleared; padding is decided by counters only.
- State IDLE: in_ready=0. On start, go to ACTIVE, busy=1. start in any other state is ignored.
- State ACTIVE: in_ready=1, except in EOL.
  - Accepted pixel (r,c) is written to line buffer 0 at c; the old line-0 value moves to line buffer 1 at c.
  - The window shifts left by one column; the new right column is {line1[c], line0[c], in_data}.
- Output latency: window centred at (r-1,c-1) is emitted registered, one cycle after pixel (r,c) is accepted, for r>=1 and c>=1. Row 0 inputs emit nothing.
- State EOL: entered the cycle after accepting c=IMG_WIDTH-1.
  - Lasts exactly 1 cycle with in_ready=0.
  - Emits window centred (r-1, IMG_WIDTH-1) with the right column padded.
  - Then returns to ACTIVE, or goes to FLUSH if r=IMG_HEIGHT-1.
- State FLUSH: in_ready=0.
  - Emits IMG_WIDTH windows for centre row IMG_HEIGHT-1, one per cycle, columns 0..IMG_WIDTH-1, bottom row padded.
  - Then DONE.
- State DONE: done=1 for one cycle, busy=0, back to IDLE.
- Total windows per frame: exactly IMG_WIDTH*IMG_HEIGHT, in raster order of centre.
- Padding: any window element outside the image is 0 (top row when centre row=0, left column when centre col=0, right/bottom similarly). No wrap-around between rows.
- in_valid while in_ready=0: beat not accepted; the upstream stage must hold data.
- Gaps in in_valid are allowed; output timing follows acceptance only.
- rstn asserted mid-frame: immediate return to IDLE, busy=0, no done pulse; the next frame requires a new start.

Optional Feature:
- Macro GRAY_WINDOW_BORDER_REPLICATE_EN.
- Defined: out-of-image elements take the nearest in-image pixel (edge clamp; corners replicate the corner pixel).
- Undefined: zero padding as above.
- Timing and window count are identical in both modes.

Decomposition:
- Shared package/include img_params holds:
  - IMG_WIDTH/IMG_HEIGHT defaults
  - DATA_WIDTH
  - state encodings (IDLE, ACTIVE, EOL, FLUSH, DONE)
  - window index constants (WIN_CENTRE=4)
- One natural sub-module: gray_line_ram, a single-clock RAM of depth IMG_WIDTH with synchronous read-before-write at the same address; instantiated twice.

Test Plan:
- Small frame, zero pad: IMG_WIDTH=4, IMG_HEIGHT=3, pixel value = 4r+c, in_valid always 1.
  - Expect first window centre (0,0) = rows {0,0,0},{0,0,1},{0,4,5}.
  - Expect centre (1,2) = {1,2,3},{5,6,7},{9,10,11}.
  - Expect exactly 12 windows, then a single done pulse.
- Same stimulus with GRAY_WINDOW_BORDER_REPLICATE_EN defined.
  - Centre (0,0) = {0,0,1},{0,0,1},{4,4,5}.
  - Centre (2,3) = {6,7,7},{10,11,11},{10,11,11}.
- Backpressure timing: check in_ready=0 for exactly 1 cycle after each row's last pixel, and for 4 cycles in FLUSH.
  - Drive in_valid=1 during those cycles with value 0xFF; it must not appear in any window.
- Bursty input: in_valid random 50% duty on the 4x3 ramp. Windows and out_row/out_col must match the continuous case in value and order.
- Reset mid-frame: drop rstn after 6 pixels.
  - Expect all outputs 0, state IDLE, no done pulse.
  - A new start plus a full frame yields a correct 12 windows.
- Full size 220x220 fed from color_control_dualport gray output: count 48400 windows; compare against a golden .hex from the reference model; done asserts once.

Source files
------------

// File: rtl/img_params_pkg.sv
// Shared image parameters for the gray raster pipeline.
//   - default frame geometry and pixel width
//   - window FSM state encoding
//   - window element indexing (k = 3*row + col, centre k = 4)
//   - clamp_sel: picks the in-image neighbour row/col used by edge replication
//     (only referenced when GRAY_WINDOW_BORDER_REPLICATE_EN is defined)
package img_params_pkg;

  localparam int IMG_WIDTH_DEF  = 220;
  localparam int IMG_HEIGHT_DEF = 220;
  localparam int DATA_WIDTH_DEF = 8;

  localparam int WIN_ELEMS  = 9;
  localparam int WIN_CENTRE = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_EOL    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } gw_state_e;

  // Window row/col index 0..2; an outside-image edge is redirected to the
  // centre row/col, which is always inside the image (W,H >= 2).
  function automatic logic [1:0] clamp_sel(input int idx, input logic lo_pad,
                                           input logic hi_pad);
    if ((idx == 0 && lo_pad) || (idx == 2 && hi_pad)) return 2'd1;
    return 2'(idx);
  endfunction

endpackage

// File: rtl/gray_line_ram.sv
// One line of pixels. Single clock, registered read; on a same-address
// read and write the read returns the old contents.
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata read data
// (valid the cycle after raddr is presented). Contents are never cleared.
module gray_line_ram #(
  parameter int DEPTH = 220,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gray_window_3x3.sv
// 3x3 neighbourhood generator for an 8-bit grayscale raster stream.
// Two line RAMs hold the previous two rows; a 3x3 register window shifts one
// column per accepted pixel, per end-of-line cycle and per flush cycle.
// One window per pixel position is emitted in raster order of its centre.
// Ports:
//   clk, rstn              clock, async active-low reset
//   start                  arms a frame (IDLE only)
//   in_valid/in_data/in_ready   pixel input handshake
//   win_valid/win_data     window out, element k=3*i+j at [DW*k +: DW]
//   out_row/out_col        centre coordinates of the window
//   busy, done             frame in progress / one-cycle completion pulse
// Option: GRAY_WINDOW_BORDER_REPLICATE_EN selects edge-clamp padding instead
// of zero padding; timing is identical.
module gray_window_3x3
  import img_params_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic                              win_valid,
  output logic [9*DATA_WIDTH-1:0]           win_data,
  output logic [$clog2(IMG_HEIGHT)-1:0]     out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]      out_col,
  output logic                              busy,
  output logic                              done
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  // col counter must reach IMG_WIDTH during flush
  localparam int CW = $clog2(IMG_WIDTH + 1);

  gw_state_e                    state_q, state_d;
  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic [WIN_ELEMS-1:0][DW-1:0] win_q, win_d;
  logic                         win_valid_q, win_valid_d;
  logic [WIN_ELEMS-1:0][DW-1:0] win_data_q, win_data_d;
  logic [RW-1:0]                out_row_q, out_row_d;
  logic [AW-1:0]                out_col_q, out_col_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         in_ready_q, in_ready_d;

  logic                         accept;
  logic [DW-1:0]                line0_rd, line1_rd;
  logic [AW-1:0]                raddr;
  logic                         shift_en;
  logic [WIN_ELEMS-1:0][DW-1:0] win_sh, win_pad;
  logic                         emit;
  logic [RW-1:0]                ctr_row;
  logic [AW-1:0]                ctr_col;
  logic                         pt, pb, pl, pr;

  assign accept = in_valid && in_ready_q;

  // Read address runs one step ahead (col_d) so the RAM output already holds
  // column col_q when that column is consumed. Writes never hit the address
  // being read, since the column advances on every write.
  assign raddr = (col_d < CW'(IMG_WIDTH)) ? AW'(col_d) : '0;

  // line0 <= new pixel, line1 <= the row line0 held before
  gray_line_ram #(.DEPTH(IMG_WIDTH), .DW(DW), .AW(AW)) u_line0 (
    .clk   (clk),
    .we    (accept),
    .waddr (AW'(col_q)),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (line0_rd)
  );

  gray_line_ram #(.DEPTH(IMG_WIDTH), .DW(DW), .AW(AW)) u_line1 (
    .clk   (clk),
    .we    (accept),
    .waddr (AW'(col_q)),
    .wdata (line0_rd),
    .raddr (raddr),
    .rdata (line1_rd)
  );

  // EOL and FLUSH shift too; whatever enters there sits in a padded column.
  assign shift_en = accept || (state_q == ST_EOL) || (state_q == ST_FLUSH);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_sh[3*i]   = win_q[3*i+1];
      win_sh[3*i+1] = win_q[3*i+2];
    end
    win_sh[2] = line1_rd;
    win_sh[5] = line0_rd;
    win_sh[8] = in_data;
  end

  // Which window leaves this cycle and where its centre is
  always_comb begin
    emit    = 1'b0;
    ctr_row = '0;
    ctr_col = '0;
    case (state_q)
      ST_ACTIVE: begin
        emit    = accept && (row_q != '0) && (col_q != '0);
        ctr_row = row_q - RW'(1);
        ctr_col = AW'(col_q - CW'(1));
      end
      ST_EOL: begin
        emit    = (row_q != '0);
        ctr_row = row_q - RW'(1);
        ctr_col = AW'(IMG_WIDTH - 1);
      end
      ST_FLUSH: begin
        emit    = 1'b1;
        ctr_row = RW'(IMG_HEIGHT - 1);
        ctr_col = AW'(col_q - CW'(1));
      end
      default: ;
    endcase
  end

  assign pt = (ctr_row == '0);
  assign pb = (ctr_row == RW'(IMG_HEIGHT - 1));
  assign pl = (ctr_col == '0);
  assign pr = (ctr_col == AW'(IMG_WIDTH - 1));

  for (genvar gi = 0; gi < 3; gi++) begin : g_r
    for (genvar gj = 0; gj < 3; gj++) begin : g_c
      localparam int K = 3*gi + gj;
`ifdef GRAY_WINDOW_BORDER_REPLICATE_EN
      logic [1:0] si, sj;
      assign si = clamp_sel(gi, pt, pb);
      assign sj = clamp_sel(gj, pl, pr);
      assign win_pad[K] = win_sh[4'(si)*4'd3 + 4'(sj)];
`else
      logic kill;
      assign kill = (gi == 0 && pt) || (gi == 2 && pb) ||
                    (gj == 0 && pl) || (gj == 2 && pr);
      assign win_pad[K] = kill ? '0 : win_sh[K];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACTIVE;
          busy_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          if (col_q == CW'(IMG_WIDTH - 1)) begin
            col_d   = '0;
            state_d = ST_EOL;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_EOL: begin
        if (row_q == RW'(IMG_HEIGHT - 1)) begin
          // column 0 was shifted in this cycle, prefetch column 1
          state_d = ST_FLUSH;
          col_d   = CW'(1);
        end else begin
          state_d = ST_ACTIVE;
          row_d   = row_q + RW'(1);
        end
      end
      ST_FLUSH: begin
        if (col_q == CW'(IMG_WIDTH)) begin
          state_d = ST_DONE;
          col_d   = '0;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        col_d   = '0;
        row_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_ACTIVE);
    win_d       = shift_en ? win_sh : win_q;
    win_valid_d = emit;
    win_data_d  = emit ? win_pad : win_data_q;
    out_row_d   = emit ? ctr_row : out_row_q;
    out_col_d   = emit ? ctr_col : out_col_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Bench for gray_window_3x3 on a 4x3 frame: ramp and random images, continuous
// and bursty input, mid-frame reset. Windows are predicted from the whole
// stored image with plain neighbourhood arithmetic.
module tb_gray_window_3x3;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;
  localparam int N  = W * H;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  start = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DW-1:0]         in_data = '0;
  logic                  in_ready, win_valid, busy, done;
  logic [9*DW-1:0]       win_data;
  logic [$clog2(H)-1:0]  out_row;
  logic [$clog2(W)-1:0]  out_col;

  always #5 clk = ~clk;

  gray_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_data  (win_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  int n_chk = 0;
  int n_err = 0;
  int img [H][W];
  int widx, done_cnt;
  bit acc, done_now, ramp;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] model_win(input int cr, input int cc);
    logic [9*DW-1:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int r = cr - 1 + i;
        int c = cc - 1 + j;
        int v;
`ifdef GRAY_WINDOW_BORDER_REPLICATE_EN
        if (r < 0) r = 0;
        if (r > H - 1) r = H - 1;
        if (c < 0) c = 0;
        if (c > W - 1) c = W - 1;
        v = img[r][c];
`else
        v = (r < 0 || r >= H || c < 0 || c >= W) ? 0 : img[r][c];
`endif
        w[DW*(3*i+j) +: DW] = DW'(v);
      end
    return w;
  endfunction

  function automatic logic [9*DW-1:0] pack9(input int e [9]);
    logic [9*DW-1:0] w = '0;
    for (int k = 0; k < 9; k++) w[DW*k +: DW] = DW'(e[k]);
    return w;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 4*r + c;
    ramp = 1'b1;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
    ramp = 1'b0;
  endtask

  // Hand-worked windows on the ramp image
  task automatic spot_check(input int idx);
    int e [9];
`ifdef GRAY_WINDOW_BORDER_REPLICATE_EN
    if (idx == 0)  begin e = '{0,0,1, 0,0,1, 4,4,5};       chk("spot_c00", 128'(win_data), 128'(pack9(e))); end
    if (idx == 11) begin e = '{6,7,7, 10,11,11, 10,11,11}; chk("spot_c23", 128'(win_data), 128'(pack9(e))); end
`else
    if (idx == 0)  begin e = '{0,0,0, 0,0,1, 0,4,5};       chk("spot_c00", 128'(win_data), 128'(pack9(e))); end
    if (idx == 11) begin e = '{6,7,0, 10,11,0, 0,0,0};     chk("spot_c23", 128'(win_data), 128'(pack9(e))); end
`endif
    if (idx == 6)  begin e = '{1,2,3, 5,6,7, 9,10,11};     chk("spot_c12", 128'(win_data), 128'(pack9(e))); end
  endtask

  // Called #1 after a rising edge; samples at the falling edge, returns #1
  // after the next rising edge.
  task automatic tick();
    @(negedge clk);
    acc      = in_valid && in_ready;
    done_now = done;
    if (win_valid) begin
      if (widx >= N) chk("extra_win", 128'(widx), 128'(N - 1));
      else begin
        chk("win_row",  128'(out_row),  128'(widx / W));
        chk("win_col",  128'(out_col),  128'(widx % W));
        chk("win_data", 128'(win_data), 128'(model_win(widx / W, widx % W)));
        if (ramp) spot_check(widx);
      end
      widx++;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_all", 128'(widx), 128'(N));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit bursty, input int abort_at, input bit poke_start);
    int idx = 0;
    int lo = 0;
    int guard = 0;
    bit was_rdy;
    widx = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", 128'(busy), 128'(1));
    while (idx < N && guard < 400) begin
      if (!in_ready) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
      end else if (bursty && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(img[idx / W][idx % W]);
      end
      start   = poke_start && (idx == 5);
      was_rdy = in_ready;
      tick();
      if (!was_rdy) lo++;
      else if (lo > 0) begin
        chk("eol_gap", 128'(lo), 128'(1));
        lo = 0;
      end
      if (acc) idx++;
      guard++;
      if (abort_at > 0 && idx == abort_at) break;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (abort_at == 0 && idx < N) chk("feed_timeout", 128'(idx), 128'(N));
  endtask

  task automatic finish_frame();
    int lat = 0;
    done_now = 1'b0;
    while (!done_now && lat < 40) begin
      chk("flush_rdy", 128'(in_ready), 128'(0));
      tick();
      lat++;
    end
    // 1 EOL + W flush + DONE cycles, then the registered pulse
    chk("done_lat",  128'(lat),      128'(W + 3));
    chk("win_count", 128'(widx),     128'(N));
    chk("done_once", 128'(done_cnt), 128'(1));
    tick();
    tick();
    chk("busy_off",    128'(busy),     128'(0));
    chk("done_single", 128'(done_cnt), 128'(1));
    chk("idle_rdy",    128'(in_ready), 128'(0));
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_in_ready"},  128'(in_ready),  128'(0));
    chk({pfx, "_win_valid"}, 128'(win_valid), 128'(0));
    chk({pfx, "_win_data"},  128'(win_data),  128'(0));
    chk({pfx, "_out_row"},   128'(out_row),   128'(0));
    chk({pfx, "_out_col"},   128'(out_col),   128'(0));
    chk({pfx, "_busy"},      128'(busy),      128'(0));
    chk({pfx, "_done"},      128'(done),      128'(0));
  endtask

  initial begin
    widx = 0;
    done_cnt = 0;
    #12;
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    tick();
    chk("idle_no_rdy", 128'(in_ready), 128'(0));

    fill_ramp();
    run_frame(1'b0, 0, 1'b0);
    finish_frame();

    fill_ramp();
    run_frame(1'b1, 0, 1'b0);
    finish_frame();

    fill_rand();
    run_frame(1'b1, 0, 1'b1);
    finish_frame();

    // reset after 6 accepted pixels
    fill_ramp();
    run_frame(1'b0, 6, 1'b0);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("midrst_no_done", 128'(done_cnt), 128'(0));
    chk("midrst_idle",    128'(in_ready), 128'(0));
    chk("midrst_busy",    128'(busy),     128'(0));

    run_frame(1'b0, 0, 1'b0);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
